// File: rtl/pic_param.sv
// ============================================================================
//  Module   : pic_param
//  Brief    : 8259-style programmable interrupt controller, single mode,
//             fixed priority (IRQ0 highest), edge/level selectable per line.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_param #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] BASE_PORT   = 16'h0020,
  parameter logic [7:0]  VECTOR_BASE = 8'h08,
  parameter logic [7:0]  LEVEL_MASK  = 8'h00
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic               iIntAck,
  input  logic [19:0]        iAddr,
  input  logic [7:0]         iWrData,
  input  logic               iWr,
  input  logic               iRd,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oData
);

  localparam logic [8:0]  c_top_bit    = 9'd1 << NUM_IRQ;
  localparam logic [7:0]  c_valid_mask = c_top_bit[7:0] - 8'd1;
  localparam logic [7:0]  c_level_bits = LEVEL_MASK & c_valid_mask;
  localparam logic [7:0]  c_edge_bits  = ~LEVEL_MASK & c_valid_mask;
  localparam logic [15:0] c_port_data  = BASE_PORT + 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ICW2 = 2'd1,
    ST_ICW4 = 2'd2
  } init_state_t;

  init_state_t r_state;
  logic [7:0]  r_irq_prev;
  logic [7:0]  r_irr;
  logic [7:0]  r_isr;
  logic [7:0]  r_imr;
  logic [4:0]  r_vbase;
  logic [7:0]  r_vector;
  logic        r_ack_phase;
  logic        r_read_sel;
  logic        r_need_icw4;
  logic        r_int;

  logic [7:0]  w_irq;
  logic        w_hit_cmd;
  logic        w_hit_data;
  logic        w_wr_cmd;
  logic        w_wr_data;
  logic        w_icw1;
  logic        w_ocw;
  logic        w_ocw2;
  logic        w_ocw3;
  logic        w_eoi_nonspec;
  logic        w_eoi_spec;
  logic        w_commit;
  logic [7:0]  w_eligible;
  logic        w_blocked;
  logic        w_found;
  logic [2:0]  w_idx;
  logic [7:0]  w_vector_new;
  logic [7:0]  w_isr_lowest;
  logic [7:0]  w_eoi_clear;
  logic [7:0]  w_commit_bit;
  logic [7:0]  w_isr_next;
  logic [7:0]  w_irr_next;
  logic [7:0]  w_rd_data;
  logic        w_unused_addr;

  assign w_irq         = 8'(iIrq);
  assign w_unused_addr = ^iAddr[19:16];

  assign w_hit_cmd  = (iAddr[15:0] == BASE_PORT);
  assign w_hit_data = (iAddr[15:0] == c_port_data);
  assign w_wr_cmd   = iWr & w_hit_cmd;
  assign w_wr_data  = iWr & w_hit_data;

  assign w_icw1        = w_wr_cmd & iWrData[4];
  assign w_ocw         = w_wr_cmd & ~iWrData[4] & (r_state == ST_IDLE);
  assign w_ocw2        = w_ocw & ~iWrData[3];
  assign w_ocw3        = w_ocw & iWrData[3];
  assign w_eoi_nonspec = w_ocw2 & (iWrData == 8'h20);
  assign w_eoi_spec    = w_ocw2 & (iWrData[7:3] == 5'b01100);

  assign w_commit = iIntAck & ~r_ack_phase;

  // A line is blocked by its own in-service bit or any higher-priority one.
  always_comb begin
    w_eligible = 8'd0;
    w_blocked  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      w_blocked     = w_blocked | r_isr[n];
      w_eligible[n] = r_irr[n] & ~r_imr[n] & ~w_blocked;
    end
    w_found = 1'b0;
    w_idx   = 3'd7;
    for (int n = 7; n >= 0; n--) begin
      if (w_eligible[n]) begin
        w_found = 1'b1;
        w_idx   = 3'(n);
      end
    end
  end

  assign w_vector_new = {r_vbase, (w_found ? w_idx : 3'd7)};

  // EOI clears land before the commit set so a same-cycle ack still wins.
  assign w_isr_lowest = r_isr & (~r_isr + 8'd1);
  assign w_eoi_clear  = w_eoi_nonspec ? w_isr_lowest :
                        w_eoi_spec    ? (8'd1 << iWrData[2:0]) : 8'd0;
  assign w_commit_bit = (w_commit & w_found) ? (8'd1 << w_idx) : 8'd0;
  assign w_isr_next   = ((w_icw1 ? 8'd0 : (r_isr & ~w_eoi_clear)) | w_commit_bit)
                        & c_valid_mask;

  assign w_irr_next = ((((w_icw1 ? 8'd0 : r_irr) & ~w_commit_bit)
                        | (w_irq & ~r_irq_prev)) & c_edge_bits)
                      | (w_irq & c_level_bits);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state     <= ST_IDLE;
      r_irq_prev  <= 8'd0;
      r_irr       <= 8'd0;
      r_isr       <= 8'd0;
      r_imr       <= 8'hFF;
      r_vbase     <= VECTOR_BASE[7:3];
      r_vector    <= 8'd0;
      r_ack_phase <= 1'b0;
      r_read_sel  <= 1'b0;
      r_need_icw4 <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      r_irq_prev <= w_irq;
      r_irr      <= w_irr_next;
      r_isr      <= w_isr_next;
      r_int      <= |w_eligible;

      if (iIntAck) begin
        r_ack_phase <= ~r_ack_phase;
        if (w_commit) begin
          r_vector <= w_vector_new;
        end
      end

      if (w_icw1) begin
        r_state     <= ST_ICW2;
        r_need_icw4 <= iWrData[0];
        r_read_sel  <= 1'b0;
        r_imr       <= ~c_valid_mask;
      end else if (w_wr_data) begin
        case (r_state)
          ST_ICW2: begin
            r_vbase <= iWrData[7:3];
            r_state <= r_need_icw4 ? ST_ICW4 : ST_IDLE;
          end
          ST_ICW4: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_imr <= iWrData | ~c_valid_mask;
          end
        endcase
      end else if (w_ocw3 & iWrData[1]) begin
        r_read_sel <= iWrData[0];
      end
    end
  end

  assign w_rd_data = w_hit_cmd ? (r_read_sel ? r_isr : r_irr) : r_imr;

  assign oInt  = r_int;
  assign oSel  = iIntAck | (iRd & (w_hit_cmd | w_hit_data));
  assign oData = iIntAck ? (w_commit ? w_vector_new : r_vector) :
                 (iRd & (w_hit_cmd | w_hit_data)) ? w_rd_data : 8'd0;

endmodule

`default_nettype wire

// File: doc/pic_param.md
PIC_PARAM -- requirements
Module: pic_param

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request inputs (1..8).
REQ-002 SHALL have parameter BASE_PORT, default 16'h0020, I/O base; BASE_PORT+0 is command/status, BASE_PORT+1 is data/mask.
REQ-003 SHALL have parameter VECTOR_BASE, default 8'h08, vector base loaded at reset.
REQ-004 SHALL have parameter LEVEL_MASK, default 8'h00, where bit n=1 makes IRQn level-triggered and 0 makes it edge-triggered.
REQ-005 SHALL have port iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port iRstN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port iIrq, input, NUM_IRQ, request lines, synchronous to iClk; IRQ0 has the highest priority.
REQ-008 SHALL have port iIntAck, input, 1, one-cycle strobe per CPU interrupt-acknowledge bus cycle.
REQ-009 SHALL have ports iAddr (20), iWrData (8), iWr (1 strobe), iRd (1), the CPU I/O bus inputs.
REQ-010 SHALL have ports oInt (1, registered interrupt request to CPU), oSel (1, read-mux select) and oData (8, read data).

Function
REQ-011 SHALL decode a port hit when iAddr[15:0] equals BASE_PORT or BASE_PORT+1, ignoring iAddr[19:16].
REQ-012 SHALL hold IRR, ISR and IMR registers of NUM_IRQ bits; bits at index NUM_IRQ or above SHALL read as 0 in IRR/ISR and as 1 in IMR.
REQ-013 Edge channel SHALL set IRR[n] one cycle after iIrq[n] goes 0->1 (prev-sample register); IRR[n] is held until acknowledge.
REQ-014 Level channel SHALL have IRR[n] equal to the registered iIrq[n] every cycle.
REQ-015 Eligible(n) SHALL mean IRR[n] & ~IMR[n] & (ISR[n:0]==0).
REQ-016 oInt SHALL be registered: high the cycle after any eligible(n) exists, low otherwise; latency from iIrq edge to oInt is 2 cycles.
REQ-017 SHALL use an ack phase flag: the first iIntAck strobe commits, the second only re-presents the vector, and the flag toggles on each strobe.
REQ-018 At commit, for the lowest eligible n: set ISR[n], clear IRR[n] (edge mode), latch vector {vbase[7:3], n[2:0]}.
REQ-019 Commit with no eligible request (spurious) SHALL latch vector {vbase[7:3],3'd7} and change neither ISR nor IRR.
REQ-020 oSel SHALL be high combinationally while iIntAck is high (oData = latched vector; at commit cycle the newly resolved vector), or while iRd is high with a port hit.
REQ-021 Read of BASE+0 SHALL return IRR when read-select is 0, or ISR when read-select is 1; read of BASE+1 SHALL return IMR.
REQ-022 Write to BASE+0 with bit4=1 (ICW1) SHALL clear ISR, IMR and read-select, clear edge-IRR bits, record needICW4=bit0, and go to state ICW2.
REQ-023 In state ICW2, the next BASE+1 write SHALL set vbase[7:3]=data[7:3] and then go to ICW4 if needICW4, else IDLE; the ICW3 write is not expected (single mode).
REQ-024 In state ICW4, the next BASE+1 write SHALL be accepted and ignored (8086 mode implied), then go to IDLE.
REQ-025 In IDLE, a BASE+1 write SHALL load IMR; masking SHALL NOT clear IRR.
REQ-026 In IDLE, a BASE+0 write with bits[4:3]=2'b00 (OCW2): data 8'h20 SHALL clear the lowest set ISR bit; data 8'h60|n SHALL clear ISR[n]; other OCW2 values SHALL be ignored.
REQ-027 In IDLE, a BASE+0 write with bits[4:3]=2'b01 (OCW3): data[1:0]=2'b10 SHALL set read-select 0, data[1:0]=2'b11 SHALL set read-select 1, and other values SHALL leave it unchanged.
REQ-028 If an edge arrives on IRQn in the same cycle that commit clears IRR[n], IRR[n] SHALL remain set.
REQ-029 If EOI and commit fall in the same cycle, the EOI clear SHALL be applied first and then the commit set.
REQ-030 A read SHALL have no side effects; iWr and iRd together SHALL perform the write.

Reset
REQ-031 While iRstN=0: IRR=0, ISR=0, IMR=all ones, vbase=VECTOR_BASE, read-select=0, init state IDLE, ack phase=0, prev-sample=0, oInt=0; oSel and oData are 0 with no strobes.
REQ-032 Reset assertion mid-acknowledge or mid-init SHALL abort it and return to the values above; the first rising iClk after deassertion behaves as a normal cycle.

Verification
REQ-033 Init: write 0x13 to 0x20, 0x08 to 0x21, 0x09 to 0x21, then 0xFC to 0x21 -> IMR reads 0xFC and state is IDLE.
REQ-034 Edge priority: iIrq[1] and iIrq[0] rise together -> oInt high 2 cycles later; ack pair returns 0x08 on both strobes and ISR=0x01; write 0x20 -> ISR=0 and a second ack returns 0x09.
REQ-035 Nesting: with ISR[1] set, IRQ0 rises -> oInt high; with ISR[0] set, IRQ1 rises -> oInt stays low until EOI.
REQ-036 Level mode (LEVEL_MASK=0x02): hold iIrq[1] high through ack and EOI -> oInt reasserts; drop it before the ack -> spurious vector 0x0F is returned and ISR is unchanged.
REQ-037 Readback: write 0x0B to 0x20 -> read 0x20 returns ISR; write 0x0A -> read returns IRR; IMR=0xFF with IRQ2 pending -> IRR bit2 is set and oInt=0.
REQ-038 Reset: pulse iRstN low during the first ack strobe -> all registers return to reset values immediately and oInt=0.
